// File: rtl/mult_share_if.sv
// Request/response channels for two requesters plus the shared multiplier port.
// The slave side is the arbiter. The master side drives requests and models the multiplier.
interface mult_share_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_instr;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_instr;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_result;
   logic        rsp0_err;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_result;
   logic        rsp1_err;
   logic        mul_valid;
   logic [31:0] mul_instr;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_ready;
   logic        mul_result_valid;
   logic [31:0] mul_result;
   logic        busy;
   logic        grant_id;

   modport slave (
      input  req0_valid, req0_instr, req0_a, req0_b,
      input  req1_valid, req1_instr, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      input  mul_ready, mul_result_valid, mul_result,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_result, rsp0_err,
      output rsp1_valid, rsp1_result, rsp1_err,
      output mul_valid, mul_instr, mul_a, mul_b,
      output busy, grant_id
   );

   modport master (
      output req0_valid, req0_instr, req0_a, req0_b,
      output req1_valid, req1_instr, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      output mul_ready, mul_result_valid, mul_result,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_err,
      input  rsp1_valid, rsp1_result, rsp1_err,
      input  mul_valid, mul_instr, mul_a, mul_b,
      input  busy, grant_id
   );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one M-extension multiplier between two requesters.
// One operation is in flight at a time. A watchdog bounds the wait for the multiplier result.
module mult_share_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic        clk,
   input logic        reset,
   mult_share_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        grant_id_q;
   logic [7:0]  cnt_q;
   logic [31:0] instr_q, a_q, b_q;
   logic [31:0] result_q;
   logic        err_q;

   logic        win0, win1, ready0, ready1, accept;
   logic [31:0] sel_instr, sel_a, sel_b;
   logic        sel_is_mul, rsp_take;

   // MUL/MULH/MULHSU/MULHU: OP opcode, funct7 = 1, funct3 in 0..3
   function automatic logic is_mul(input logic [31:0] instr);
      return (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001) && !instr[14];
   endfunction

   always_comb begin
      win0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      win1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
      // Readies are gated by reset so every output reads 0 while reset is held
      ready0 = reset && (state_q == IDLE) && win0;
      ready1 = reset && (state_q == IDLE) && win1;
      accept = ready0 || ready1;
      sel_instr  = ready1 ? bus.req1_instr : bus.req0_instr;
      sel_a      = ready1 ? bus.req1_a     : bus.req0_a;
      sel_b      = ready1 ? bus.req1_b     : bus.req0_b;
      sel_is_mul = is_mul(sel_instr);
      rsp_take   = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = sel_is_mul ? ISSUE : RESP;
         ISSUE: if (bus.mul_ready) state_d = WAIT;
         WAIT:  if (bus.mul_result_valid || cnt_q == TO_LAST) state_d = RESP;
         RESP:  if (rsp_take) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         cnt_q        <= 8'd0;
         instr_q      <= 32'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         result_q     <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  instr_q      <= sel_instr;
                  a_q          <= sel_a;
                  b_q          <= sel_b;
                  grant_id_q   <= ready1;
                  last_grant_q <= ready1;
                  result_q     <= 32'd0;
                  err_q        <= !sel_is_mul;
               end
            end
            ISSUE: begin
               if (bus.mul_ready) cnt_q <= 8'd0;
            end
            WAIT: begin
               if (bus.mul_result_valid) begin
                  result_q <= bus.mul_result;
                  err_q    <= 1'b0;
               end else if (cnt_q == TO_LAST) begin
                  result_q <= 32'd0;
                  err_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.mul_valid   = (state_q == ISSUE);
   assign bus.mul_instr   = instr_q;
   assign bus.mul_a       = a_q;
   assign bus.mul_b       = b_q;
   assign bus.rsp0_valid  = (state_q == RESP) && !grant_id_q;
   assign bus.rsp1_valid  = (state_q == RESP) &&  grant_id_q;
   assign bus.rsp0_result = result_q;
   assign bus.rsp1_result = result_q;
   assign bus.rsp0_err    = err_q;
   assign bus.rsp1_err    = err_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: single op, fairness, non-multiply, backpressure,
// timeout and reset mid-operation, with the multiplier modelled by directed stimulus.
module tb_mult_share_ctrl;

   localparam logic [31:0] MUL_I = 32'h02B50533;
   localparam logic [31:0] ADD_I = 32'h00B50533;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   mult_share_if bus ();

   mult_share_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_single();
      bus.req0_valid = 1'b1; bus.req0_instr = MUL_I; bus.req0_a = 32'd7; bus.req0_b = 32'd6;
      bus.mul_ready = 1'b1;
      #1;
      chk("single_ready0", bus.req0_ready, 1);
      chk("single_ready1", bus.req1_ready, 0);
      step();
      bus.req0_valid = 1'b0;
      bus.mul_result_valid = 1'b1; bus.mul_result = 32'hDEAD;
      chk("single_mul_valid", bus.mul_valid, 1);
      chk("single_mul_a", bus.mul_a, 7);
      chk("single_mul_b", bus.mul_b, 6);
      chk("single_mul_instr", bus.mul_instr, MUL_I);
      chk("single_busy", bus.busy, 1);
      step();
      chk("single_wait_mul_valid", bus.mul_valid, 0);
      chk("single_wait_mul_a", bus.mul_a, 7);
      chk("single_wait_no_rsp", bus.rsp0_valid, 0);
      bus.mul_result = 32'd42;
      step();
      bus.mul_result_valid = 1'b0;
      chk("single_rsp0_valid", bus.rsp0_valid, 1);
      chk("single_rsp1_valid", bus.rsp1_valid, 0);
      chk("single_result", bus.rsp0_result, 42);
      chk("single_err", bus.rsp0_err, 0);
      chk("single_grant", bus.grant_id, 0);
      bus.rsp0_ready = 1'b1;
      step();
      bus.rsp0_ready = 1'b0;
      chk("single_idle_busy", bus.busy, 0);
      chk("single_idle_rsp0", bus.rsp0_valid, 0);
   endtask

   initial begin
      int k0;
      int k1;
      int hi_cnt;
      reset = 1'b0;
      bus.req0_valid = 0; bus.req0_instr = 0; bus.req0_a = 0; bus.req0_b = 0;
      bus.req1_valid = 0; bus.req1_instr = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
      bus.mul_ready = 0; bus.mul_result_valid = 0; bus.mul_result = 0;
      step();
      step();
      // Reset state, with a pending request that must not be granted
      bus.req0_valid = 1'b1;
      #1;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant", bus.grant_id, 0);
      chk("rst_mul_valid", bus.mul_valid, 0);
      chk("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
      bus.req0_valid = 1'b0;
      reset = 1'b1;

      run_single();

      // Non-multiply on req1
      bus.req1_valid = 1'b1; bus.req1_instr = ADD_I; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
      #1;
      chk("nm_ready1", bus.req1_ready, 1);
      step();
      bus.req1_valid = 1'b0;
      chk("nm_rsp1_valid", bus.rsp1_valid, 1);
      chk("nm_rsp0_valid", bus.rsp0_valid, 0);
      chk("nm_result", bus.rsp1_result, 0);
      chk("nm_err", bus.rsp1_err, 1);
      chk("nm_mul_valid", bus.mul_valid, 0);
      chk("nm_grant", bus.grant_id, 1);
      bus.rsp1_ready = 1'b1;
      step();
      bus.rsp1_ready = 1'b0;
      chk("nm_idle", bus.busy, 0);

      // Fairness: both requesters valid for eight back-to-back multiplies
      k0 = 0; k1 = 0;
      bus.req0_valid = 1'b1; bus.req0_instr = MUL_I; bus.req0_a = 32'd10; bus.req0_b = 32'd3;
      bus.req1_valid = 1'b1; bus.req1_instr = MUL_I; bus.req1_a = 32'd20; bus.req1_b = 32'd5;
      bus.mul_ready = 1'b1; bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("fair_ready_%0d", i), {bus.req1_ready, bus.req0_ready}, (i % 2) ? 2 : 1);
         step();
         chk($sformatf("fair_grant_%0d", i), bus.grant_id, i % 2);
         if (i % 2 == 0) begin
            chk($sformatf("fair_mul_a_%0d", i), bus.mul_a, 10 + k0);
            bus.mul_result = (10 + k0) * 3;
         end else begin
            chk($sformatf("fair_mul_a_%0d", i), bus.mul_a, 20 + k1);
            bus.mul_result = (20 + k1) * 5;
         end
         step();
         bus.mul_result_valid = 1'b1;
         step();
         bus.mul_result_valid = 1'b0;
         chk($sformatf("fair_rsp_%0d", i), {bus.rsp1_valid, bus.rsp0_valid}, (i % 2) ? 2 : 1);
         if (i % 2 == 0) begin
            chk($sformatf("fair_res_%0d", i), bus.rsp0_result, (10 + k0) * 3);
            k0++;
            bus.req0_a = 32'(10 + k0);
         end else begin
            chk($sformatf("fair_res_%0d", i), bus.rsp1_result, (20 + k1) * 5);
            k1++;
            bus.req1_a = 32'(20 + k1);
         end
         step();
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      // Multiplier backpressure: mul_ready low for three ISSUE cycles
      bus.req0_valid = 1'b1; bus.req0_instr = MUL_I; bus.req0_a = 32'd9; bus.req0_b = 32'd11;
      bus.mul_ready = 1'b0;
      step();
      bus.req0_valid = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.mul_ready = 1'b1;
         if (bus.mul_valid) hi_cnt++;
         chk($sformatf("bp_mul_a_%0d", i), bus.mul_a, 9);
         chk($sformatf("bp_mul_b_%0d", i), bus.mul_b, 11);
         step();
      end
      chk("bp_mul_valid_cycles", hi_cnt, 4);
      chk("bp_wait_mul_valid", bus.mul_valid, 0);
      bus.mul_result_valid = 1'b1; bus.mul_result = 32'd99;
      step();
      bus.mul_result_valid = 1'b0;
      // Response backpressure with a competing request that must stay blocked
      bus.req1_valid = 1'b1; bus.req1_instr = MUL_I;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rbp_valid_%0d", i), bus.rsp0_valid, 1);
         chk($sformatf("rbp_result_%0d", i), bus.rsp0_result, 99);
         chk($sformatf("rbp_err_%0d", i), bus.rsp0_err, 0);
         chk($sformatf("rbp_ready1_%0d", i), bus.req1_ready, 0);
         step();
      end
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b1;
      step();
      bus.rsp0_ready = 1'b0;
      chk("rbp_idle", bus.busy, 0);

      // Timeout: multiplier never answers
      bus.req0_valid = 1'b1; bus.req0_instr = MUL_I; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
      bus.mul_ready = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_wait_%0d", i), bus.rsp0_valid, 0);
         step();
      end
      chk("to_rsp_valid", bus.rsp0_valid, 1);
      chk("to_err", bus.rsp0_err, 1);
      chk("to_result", bus.rsp0_result, 0);
      bus.rsp0_ready = 1'b1;
      step();
      bus.rsp0_ready = 1'b0;

      // Reset during WAIT, then a late result that must be ignored
      bus.req0_valid = 1'b1; bus.req0_instr = MUL_I; bus.req0_a = 32'd4; bus.req0_b = 32'd5;
      step();
      bus.req0_valid = 1'b0;
      step();
      chk("mr_in_wait", bus.busy, 1);
      reset = 1'b0;
      step();
      chk("mr_busy", bus.busy, 0);
      chk("mr_mul_valid", bus.mul_valid, 0);
      chk("mr_mul_a", bus.mul_a, 0);
      chk("mr_mul_b", bus.mul_b, 0);
      chk("mr_mul_instr", bus.mul_instr, 0);
      chk("mr_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
      chk("mr_result", bus.rsp0_result, 0);
      chk("mr_err", {bus.rsp1_err, bus.rsp0_err}, 0);
      chk("mr_grant", bus.grant_id, 0);
      chk("mr_readies", {bus.req1_ready, bus.req0_ready}, 0);
      reset = 1'b1;
      bus.mul_result_valid = 1'b1; bus.mul_result = 32'd20;
      step();
      chk("mr_late_busy", bus.busy, 0);
      chk("mr_late_rsp", bus.rsp0_valid, 0);
      bus.mul_result_valid = 1'b0;
      step();
      chk("mr_late_rsp2", bus.rsp0_valid, 0);
      // After reset req0 wins a simultaneous request
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      chk("mr_first_winner", {bus.req1_ready, bus.req0_ready}, 1);
      bus.req1_valid = 1'b0;
      run_single();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Two-port arbiter and sequencer that shares one M-extension multiplier between two requesters, such as two issue slots or two harts. It accepts MUL/MULH/MULHSU/MULHU requests over valid/ready channels and grants one requester at a time, round-robin. It drives the multiplier's valid/instruction/operand inputs, captures the result, and returns it with an error flag on the granted requester's response channel. It also bounds each operation with a watchdog timeout.

## Interface

- TIMEOUT_CYCLES, default 16: max WAIT cycles before an error response. Legal range 1..255.

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_instr / req1_instr  in  32  RV32 instruction word
- req0_a, req0_b / req1_a, req1_b  in  32  rs1 / rs2 operands
- rsp0_valid / rsp1_valid  out  1  response present
- rsp0_ready / rsp1_ready  in  1  response consumed
- rsp0_result / rsp1_result  out  32  product word
- rsp0_err / rsp1_err  out  1  1 = not a multiply, or timed out
- mul_valid  out  1  to multiplier mult_i_valid
- mul_instr, mul_a, mul_b  out  32  to multiplier instruction / operand_a_i / operand_b_i
- mul_ready  in  1  from multiplier mult_o_ready
- mul_result_valid  in  1  from multiplier result_o_valid
- mul_result  in  32  from multiplier result
- busy  out  1  state != IDLE
- grant_id  out  1  id of the current or last granted requester

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one operation is in flight at a time.
- **Arbitration in IDLE (combinational):**
  - If only one requester is valid, that requester wins.
  - If both are valid, the winner is the requester not equal to last_grant.
  - The winner's reqN_ready = 1. The other ready and both readies outside IDLE = 0.
- **Accept (valid & ready):**
  - Latch instr, a, b and id. Set last_grant and grant_id to id.
  - Multiply decode: opcode = 0110011, funct7 = 0000001, funct3[2] = 0.
  - Multiply → ISSUE.
  - Otherwise → RESP with result = 0, err = 1. The multiplier is untouched.
- **ISSUE:**
  - mul_valid = 1, with mul_instr/a/b driven from the latched registers.
  - mul_ready = 1 → WAIT with the counter cleared. mul_valid is asserted for exactly this one accepted cycle.
  - mul_ready = 0 → stay in ISSUE, holding mul_valid and operands stable.
- **WAIT:**
  - mul_valid = 0. mul_instr/a/b keep their latched values.
  - mul_result_valid = 1 → capture mul_result, err = 0, → RESP.
  - Otherwise the counter increments. If the counter == TIMEOUT_CYCLES-1 and still no valid: result = 0, err = 1, → RESP.
  - mul_result_valid is ignored outside WAIT.
- **RESP:**
  - rspN_valid = 1 for the latched id only. result and err are held stable.
  - rspN_ready = 1 → IDLE.
- **Reset (reset = 0 at an edge):**
  - State → IDLE, last_grant = 1 (so req0 wins first), grant_id = 0, counter = 0.
  - All data registers are cleared.
  - A reset mid-operation abandons the operation. A late mul_result_valid is ignored.
- **Output values in reset:** all outputs are 0, including the readies, rsp*_valid, mul_valid and busy. mul_instr/a/b are 0.

## Timing

- Request accepted at edge T:
  - ISSUE during cycle T+1, mul_valid = 1.
  - With mul_ready = 1: WAIT from T+2.
  - If mul_result_valid is seen at WAIT cycle k (k ≥ 0): rspN_valid from cycle T+3+k.
- Non-multiply accepted at edge T: rspN_valid at T+1.
- Response consumed at edge R: IDLE in R+1. Earliest next accept is at edge R+1.
- Minimum occupancy per multiply: 4 cycles.
- Timeout: exactly TIMEOUT_CYCLES WAIT cycles, then RESP.
- reqN_ready depends combinationally on reqN_valid and state. All other outputs are registered or decoded from state.

## Test plan

- **Single multiply:** reset released; req0: instr 0x02B50533 (mul), a = 7, b = 6. Multiplier model returns 42 one cycle after issue.
  - Expect: one mul_valid pulse carrying 7/6, then rsp0_valid with result 42, err 0, grant_id 0, and rsp1_valid never asserted.
- **Fairness:** req0 and req1 both valid continuously with 4 multiplies each.
  - Expect: grants 0,1,0,1,0,1,0,1, each response routed to the correct port.
- **Non-multiply:** req1 instr 0x00B50533 (add).
  - Expect: rsp1_valid one cycle after accept, result 0, err 1, mul_valid never asserted.
- **Backpressure:**
  - mul_ready held low 3 cycles in ISSUE → mul_valid high 4 cycles with stable operands, exactly one accepted.
  - rsp0_ready held low 5 cycles → rsp0_valid, result and err stable, with no new accepts.
- **Timeout:** TIMEOUT_CYCLES = 4, model never raises result_valid.
  - Expect: rsp0 err 1, result 0, exactly 4 WAIT cycles after issue.
- **Reset mid-operation:** reset = 0 during WAIT, then the model raises result_valid after release.
  - Expect: all outputs 0 the cycle after the reset edge, no response emitted, and the next request behaves per the single-multiply scenario.
